// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths and types for the PWM generator and capture blocks.
//   COUNT_W     - width of period/compare/measurement counters
//   cap_state_t - capture FSM states
package pwm_pkg;
    localparam int COUNT_W = 16;
    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} cap_state_t;
endpackage

// File: rtl/pwm_sync_edge.sv
// pwm_sync_edge: synchronises an async input and flags its rising/falling edges.
//   clk, rst_n - clock, async active-low reset
//   d          - asynchronous input
//   level      - synchronised level
//   rise, fall - one-cycle edge strobes, same latency for both edges
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
            prev <= sync[SYNC_STAGES-1];
        end
    end
    assign level = sync[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an external PWM input in clk cycles.
//   clk, rst_n  - clock, async active-low reset
//   cap_en      - capture enable (level); low aborts and returns to IDLE
//   clr_ovf     - pulse clearing the sticky overflow flag
//   pwm_in      - asynchronous PWM input
//   meas_period - last complete period (rise to rise)
//   meas_high   - high time of that period (rise to fall)
//   meas_valid  - one-cycle pulse when meas_* update
//   ovf         - sticky: counter saturated with no edge
//   level       - synchronised input level
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cap_en,
    input  logic               clr_ovf,
    input  logic               pwm_in,
    output logic [COUNT_W-1:0] meas_period,
    output logic [COUNT_W-1:0] meas_high,
    output logic               meas_valid,
    output logic               ovf,
    output logic               level
);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;
    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);
    cap_state_t         state, state_n;
    logic [COUNT_W-1:0] cnt, cnt_n, high_lat, high_lat_n, meas_period_n, meas_high_n;
    logic               meas_valid_n, ovf_set, rise, fall;
    pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        high_lat_n    = high_lat;
        meas_period_n = meas_period;
        meas_high_n   = meas_high;
        meas_valid_n  = 1'b0;
        ovf_set       = 1'b0;
        if (!cap_en) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_n   = '0;
                    state_n = ARM;
                end
                ARM: if (rise) begin
                    cnt_n   = CNT_ONE;
                    state_n = HIGH;
                end
                HIGH: if (fall) begin
                    high_lat_n = cnt;
                    // a 65535-cycle high phase leaves cnt pinned so LOW overflows next cycle
                    cnt_n      = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
                    state_n    = LOW;
                end else if (cnt == CNT_MAX) begin
                    ovf_set = 1'b1;
                    state_n = ARM;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
                LOW: if (rise) begin
                    // closing rise also opens the next period
                    meas_period_n = cnt;
                    meas_high_n   = high_lat;
                    meas_valid_n  = 1'b1;
                    cnt_n         = CNT_ONE;
                    state_n       = HIGH;
                end else if (cnt == CNT_MAX) begin
                    ovf_set = 1'b1;
                    state_n = ARM;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            high_lat    <= '0;
            meas_period <= '0;
            meas_high   <= '0;
            meas_valid  <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            high_lat    <= high_lat_n;
            meas_period <= meas_period_n;
            meas_high   <= meas_high_n;
            meas_valid  <= meas_valid_n;
            ovf         <= ovf_set | (ovf & ~clr_ovf);
        end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized self-checking bench for pwm_capture against a segment-level model.
module tb_pwm_capture;
    localparam int S = 2;
    logic        clk = 1'b0, rst_n = 1'b0, cap_en = 1'b0, clr_ovf = 1'b0, pwm_in = 1'b0;
    logic [15:0] meas_period, meas_high;
    logic        meas_valid, ovf, level;
    int checks = 0, errors = 0, cyc = 0, obs_rd = 0, last_p = 0, last_h = 0;
    int obs_p[$], obs_h[$], obs_c[$], exp_p[$], exp_h[$], exp_c[$];
    int seg_h[64], seg_l[64];

    pwm_capture #(.SYNC_STAGES(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cap_en      (cap_en),
        .clr_ovf     (clr_ovf),
        .pwm_in      (pwm_in),
        .meas_period (meas_period),
        .meas_high   (meas_high),
        .meas_valid  (meas_valid),
        .ovf         (ovf),
        .level       (level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (meas_valid) begin
        obs_p.push_back(int'(meas_period));
        obs_h.push_back(int'(meas_high));
        obs_c.push_back(cyc);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: every rise after the first closes the previous segment, reported S+1 edges later.
    task automatic play(input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = 1'b1;
            if (i > 0) begin
                exp_p.push_back(seg_h[i-1] + seg_l[i-1]);
                exp_h.push_back(seg_h[i-1]);
                exp_c.push_back(cyc + S + 1);
                last_p = seg_h[i-1] + seg_l[i-1];
                last_h = seg_h[i-1];
            end
            tick(seg_h[i]);
            pwm_in = 1'b0;
            tick(seg_l[i]);
        end
    endtask

    task automatic rearm();
        cap_en = 1'b0;
        pwm_in = 1'b0;
        tick(S + 3);
        cap_en = 1'b1;
        tick(3);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        cap_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            pwm_in = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if ({meas_period, meas_high, meas_valid, ovf, level} !== 35'd0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got %h, expected 0", i, {meas_period, meas_high, meas_valid, ovf, level});
            end
            @(posedge clk);
            #1;
        end
        cap_en = 1'b0;
        rst_n  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pwm_in = 1'b1;
            tick(10);
            pwm_in = 1'b0;
            tick(15);
        end
        checks++;
        if (obs_p.size() !== 0 || meas_period !== 16'd0 || meas_high !== 16'd0) begin
            errors++;
            $display("FAIL disabled_no_meas: pulses=%0d period=%0d high=%0d, expected 0/0/0", obs_p.size(), meas_period, meas_high);
        end
        pwm_in = 1'b1;
        tick(S + 1);
        @(negedge clk);
        checks++;
        if (level !== 1'b1) begin
            errors++;
            $display("FAIL level_high: got %b expected 1", level);
        end
        pwm_in = 1'b0;
        tick(S + 1);
        @(negedge clk);
        checks++;
        if (level !== 1'b0) begin
            errors++;
            $display("FAIL level_low: got %b expected 0", level);
        end
    endtask

    task automatic test_basic();
        rearm();
        for (int i = 0; i < 7; i++) begin
            seg_h[i] = 10;
            seg_l[i] = 15;
        end
        play(7);
        tick(S + 3);
        checks++;
        if (obs_p.size() - obs_rd !== exp_p.size()) begin
            errors++;
            $display("FAIL basic_count: got %0d pulses, expected %0d", obs_p.size() - obs_rd, exp_p.size());
        end
        for (int i = 0; i < exp_p.size() && obs_rd + i < obs_p.size(); i++) begin
            checks++;
            if (obs_p[obs_rd+i] !== exp_p[i] || obs_h[obs_rd+i] !== exp_h[i] || obs_c[obs_rd+i] !== exp_c[i]) begin
                errors++;
                $display("FAIL basic[%0d]: period/high/cycle %0d/%0d/%0d, expected %0d/%0d/%0d", i,
                         obs_p[obs_rd+i], obs_h[obs_rd+i], obs_c[obs_rd+i], exp_p[i], exp_h[i], exp_c[i]);
            end
        end
        obs_rd = obs_p.size();
        exp_p.delete(); exp_h.delete(); exp_c.delete();
    endtask

    task automatic test_change();
        rearm();
        for (int i = 0; i < 8; i++) begin
            seg_h[i] = (i < 3) ? 10 : 3;
            seg_l[i] = (i < 3) ? 15 : 4;
        end
        play(8);
        tick(S + 3);
        checks++;
        if (obs_p.size() - obs_rd !== exp_p.size()) begin
            errors++;
            $display("FAIL change_count: got %0d pulses, expected %0d", obs_p.size() - obs_rd, exp_p.size());
        end
        for (int i = 0; i < exp_p.size() && obs_rd + i < obs_p.size(); i++) begin
            checks++;
            if (obs_p[obs_rd+i] !== exp_p[i] || obs_h[obs_rd+i] !== exp_h[i] || obs_c[obs_rd+i] !== exp_c[i]) begin
                errors++;
                $display("FAIL change[%0d]: period/high/cycle %0d/%0d/%0d, expected %0d/%0d/%0d", i,
                         obs_p[obs_rd+i], obs_h[obs_rd+i], obs_c[obs_rd+i], exp_p[i], exp_h[i], exp_c[i]);
            end
        end
        obs_rd = obs_p.size();
        exp_p.delete(); exp_h.delete(); exp_c.delete();
    endtask

    task automatic test_random();
        rearm();
        for (int i = 0; i < 24; i++) begin
            seg_h[i] = int'($urandom_range(1, 30));
            seg_l[i] = int'($urandom_range(1, 30));
        end
        play(24);
        tick(S + 3);
        checks++;
        if (obs_p.size() - obs_rd !== exp_p.size()) begin
            errors++;
            $display("FAIL random_count: got %0d pulses, expected %0d", obs_p.size() - obs_rd, exp_p.size());
        end
        for (int i = 0; i < exp_p.size() && obs_rd + i < obs_p.size(); i++) begin
            checks++;
            if (obs_p[obs_rd+i] !== exp_p[i] || obs_h[obs_rd+i] !== exp_h[i] || obs_c[obs_rd+i] !== exp_c[i]) begin
                errors++;
                $display("FAIL random[%0d]: period/high/cycle %0d/%0d/%0d, expected %0d/%0d/%0d", i,
                         obs_p[obs_rd+i], obs_h[obs_rd+i], obs_c[obs_rd+i], exp_p[i], exp_h[i], exp_c[i]);
            end
        end
        obs_rd = obs_p.size();
        exp_p.delete(); exp_h.delete(); exp_c.delete();
    endtask

    task automatic test_ovf();
        rearm();
        pwm_in = 1'b1;
        tick(S + 65535);
        @(negedge clk);
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_early: got %b expected 0", ovf);
        end
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        @(negedge clk);
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_beats_clear: got %b expected 1", ovf);
        end
        tick(400);
        checks++;
        if (obs_p.size() !== obs_rd || int'(meas_period) !== last_p || int'(meas_high) !== last_h) begin
            errors++;
            $display("FAIL ovf_hold: pulses=%0d period=%0d high=%0d, expected %0d/%0d/%0d",
                     obs_p.size(), meas_period, meas_high, obs_rd, last_p, last_h);
        end
        pwm_in = 1'b0;
        tick(15);
        for (int i = 0; i < 4; i++) begin
            seg_h[i] = 10;
            seg_l[i] = 15;
        end
        play(4);
        tick(S + 3);
        checks++;
        if (obs_p.size() - obs_rd !== exp_p.size()) begin
            errors++;
            $display("FAIL ovf_resume_count: got %0d pulses, expected %0d", obs_p.size() - obs_rd, exp_p.size());
        end
        for (int i = 0; i < exp_p.size() && obs_rd + i < obs_p.size(); i++) begin
            checks++;
            if (obs_p[obs_rd+i] !== exp_p[i] || obs_h[obs_rd+i] !== exp_h[i] || obs_c[obs_rd+i] !== exp_c[i]) begin
                errors++;
                $display("FAIL ovf_resume[%0d]: period/high/cycle %0d/%0d/%0d, expected %0d/%0d/%0d", i,
                         obs_p[obs_rd+i], obs_h[obs_rd+i], obs_c[obs_rd+i], exp_p[i], exp_h[i], exp_c[i]);
            end
        end
        obs_rd = obs_p.size();
        exp_p.delete(); exp_h.delete(); exp_c.delete();
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b expected 1", ovf);
        end
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        @(negedge clk);
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 0", ovf);
        end
    endtask

    task automatic test_abort();
        rearm();
        for (int i = 0; i < 3; i++) begin
            seg_h[i] = 10;
            seg_l[i] = 15;
        end
        play(3);
        pwm_in = 1'b1;
        exp_p.push_back(25);
        exp_h.push_back(10);
        exp_c.push_back(cyc + S + 1);
        last_p = 25;
        last_h = 10;
        tick(6);
        cap_en = 1'b0;
        tick(2);
        cap_en = 1'b1;
        tick(2);
        pwm_in = 1'b0;
        tick(15);
        checks++;
        if (int'(meas_period) !== last_p || int'(meas_high) !== last_h) begin
            errors++;
            $display("FAIL abort_hold: period/high %0d/%0d, expected %0d/%0d", meas_period, meas_high, last_p, last_h);
        end
        for (int i = 0; i < 3; i++) begin
            seg_h[i] = 7;
            seg_l[i] = 5;
        end
        play(3);
        tick(S + 3);
        checks++;
        if (obs_p.size() - obs_rd !== exp_p.size()) begin
            errors++;
            $display("FAIL abort_count: got %0d pulses, expected %0d", obs_p.size() - obs_rd, exp_p.size());
        end
        for (int i = 0; i < exp_p.size() && obs_rd + i < obs_p.size(); i++) begin
            checks++;
            if (obs_p[obs_rd+i] !== exp_p[i] || obs_h[obs_rd+i] !== exp_h[i] || obs_c[obs_rd+i] !== exp_c[i]) begin
                errors++;
                $display("FAIL abort[%0d]: period/high/cycle %0d/%0d/%0d, expected %0d/%0d/%0d", i,
                         obs_p[obs_rd+i], obs_h[obs_rd+i], obs_c[obs_rd+i], exp_p[i], exp_h[i], exp_c[i]);
            end
        end
        obs_rd = obs_p.size();
        exp_p.delete(); exp_h.delete(); exp_c.delete();
    endtask

    task automatic test_midreset();
        rearm();
        for (int i = 0; i < 3; i++) begin
            seg_h[i] = 10;
            seg_l[i] = 15;
        end
        play(3);
        pwm_in = 1'b1;
        tick(6);
        checks++;
        if (meas_period !== 16'd25) begin
            errors++;
            $display("FAIL midreset_pre: period %0d expected 25", meas_period);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({meas_period, meas_high, meas_valid, ovf, level} !== 35'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h, expected 0", {meas_period, meas_high, meas_valid, ovf, level});
        end
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        pwm_in = 1'b0;
        obs_rd = obs_p.size();
        exp_p.delete(); exp_h.delete(); exp_c.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_change();
        test_random();
        test_ovf();
        test_abort();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
